bcd_stopwatch_ctrl: RTL
=======================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 10, meaning clock cycles per count tick (legal 2..65535).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port start_stop, input, 1, one-cycle command pulse that toggles run/pause.
REQ-005 The block SHALL have port clear, input, 1, one-cycle command pulse that zeroes the count.
REQ-006 The block SHALL have port lap, input, 1, one-cycle pulse that toggles the display hold.
REQ-007 The block SHALL have port digits, output, 16, four BCD digits; [15:12] is the most significant.
REQ-008 The block SHALL have port running, output, 1, high while in RUN.
REQ-009 The block SHALL have port overflow, output, 1, sticky flag set on the 9999->0000 wrap.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, RUN and PAUSE.
REQ-011 Transitions SHALL be: IDLE+start_stop->RUN; RUN+start_stop->PAUSE; PAUSE+start_stop->RUN; PAUSE+clear->IDLE.
REQ-012 Clear in RUN SHALL be ignored; clear in IDLE SHALL keep the count at 0000 and deassert overflow.
REQ-013 When start_stop and clear coincide, clear SHALL win in PAUSE/IDLE and start_stop SHALL win in RUN.
REQ-014 The prescaler SHALL count 0..PRESCALE-1 only in RUN, hold in PAUSE, and be 0 in IDLE.
REQ-015 The count SHALL increment on each edge in RUN where the prescaler equals PRESCALE-1, and the prescaler SHALL wrap to 0 on that edge.
REQ-016 First increment latency from the edge sampling start_stop in IDLE SHALL be exactly PRESCALE cycles.
REQ-017 Each digit SHALL count 0..9; a digit at 9 receiving an increment SHALL go to 0 and carry into the next digit in the same edge.
REQ-018 Count 9999 plus one increment SHALL give 0000 and set overflow on that edge; overflow SHALL stay set until clear in IDLE/PAUSE or reset.
REQ-019 The digit registers SHALL never hold a value above 9.
REQ-020 running SHALL be a registered decode of state == RUN, with no extra latency relative to the state.

Reset
REQ-021 Reset SHALL force, without waiting for clk: state IDLE, prescaler 0, count 0000, digits 0x0000, running 0, overflow 0, lap hold released.
REQ-022 Reset asserted mid-RUN SHALL abandon the count; after release the block SHALL wait in IDLE for start_stop.

Configuration
REQ-023 With macro BCD_SW_LAP_EN defined, a lap pulse in RUN or PAUSE SHALL toggle hold.
REQ-024 With BCD_SW_LAP_EN defined, entering hold SHALL capture the live count into a lap register, and digits SHALL show that register while hold is set.
REQ-025 With BCD_SW_LAP_EN defined, counting SHALL continue underneath hold, lap in IDLE SHALL be ignored, and clear SHALL release hold.
REQ-026 Without BCD_SW_LAP_EN, the lap port SHALL remain but be ignored, no lap register SHALL be built, and digits SHALL always equal the live count.

Structure
REQ-027 Package bcd_sw_pkg SHALL hold the state enum (IDLE/RUN/PAUSE) and the constants BCD_W=4 and NUM_DIGITS=4.
REQ-028 Sub-module bcd_digit SHALL be instantiated four times in a carry chain.
REQ-029 bcd_digit SHALL have ports clk, reset, clr, inc, q[3:0] and carry, with carry = inc && q==9 (combinational).
REQ-030 The FSM, prescaler and lap logic SHALL reside in bcd_stopwatch_ctrl.

Verification
REQ-031 PRESCALE=10, start_stop pulse at cycle 0 -> running=1 at cycle 1, digits=0x0001 after exactly 10 cycles, 0x0012 after 120.
REQ-032 Run to 0x0099, next tick -> 0x0100; run to 0x9999, next tick -> 0x0000 with overflow=1, and overflow stays 1 while counting continues.
REQ-033 Pause at 0x0042, wait 100 cycles -> digits held at 0x0042; clear with start_stop in the same cycle -> IDLE, 0x0000, overflow=0.
REQ-034 Clear pulse in RUN at 0x0005 -> ignored, count continues to 0x0006.
REQ-035 BCD_SW_LAP_EN: lap at 0x0030 -> digits frozen at 0x0030 for 50 ticks; second lap -> digits show the live count (0x0080).
REQ-036 reset pulsed asynchronously mid-tick in RUN -> all outputs 0 immediately; no increment after release until a new start_stop.

Source files
------------

// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_sw_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch count: 0..9 with a combinational carry into the next decade.
module bcd_digit
  import bcd_sw_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == BCD_W'(9)) ? '0 : r_q + 1'b1;
    end
  end

  assign q     = r_q;
  assign carry = inc && (r_q == BCD_W'(9));

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: run/pause/clear FSM, tick prescaler and sticky overflow.
// Optional lap-hold display is built only when BCD_SW_LAP_EN is defined.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_stop,
  input  logic                        clear,
  input  logic                        lap,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        running,
  output logic                        overflow
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  sw_state_e                   r_state;
  sw_state_e                   w_next;
  logic [PRE_W-1:0]            r_pre;
  logic                        r_running;
  logic                        r_overflow;
  logic                        w_tick;
  logic                        w_clr_cnt;
  logic [NUM_DIGITS:0]         w_inc;
  logic [NUM_DIGITS*BCD_W-1:0] w_count;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_stop && !clear) w_next = RUN;
      RUN:     if (start_stop)           w_next = PAUSE;
      PAUSE: begin
        if (clear)           w_next = IDLE;
        else if (start_stop) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == RUN);
    end
  end

  // Clear is only honoured outside RUN; it also zeroes the count and overflow.
  assign w_clr_cnt = clear && (r_state != RUN);
  assign w_tick    = (r_state == RUN) && (r_pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (r_state == IDLE || w_clr_cnt) begin
      r_pre <= '0;
    end else if (r_state == RUN) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  assign w_inc[0] = w_tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr_cnt),
      .inc   (w_inc[g]),
      .q     (w_count[g*BCD_W +: BCD_W]),
      .carry (w_inc[g+1])
    );
  end

  // Carry out of the top decade marks the 9999 -> 0000 wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_clr_cnt) begin
      r_overflow <= 1'b0;
    end else if (w_inc[NUM_DIGITS]) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef BCD_SW_LAP_EN
  logic                        r_hold;
  logic [NUM_DIGITS*BCD_W-1:0] r_lap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else if (w_clr_cnt) begin
      r_hold <= 1'b0;
    end else if (lap && (r_state != IDLE)) begin
      r_hold <= !r_hold;
      if (!r_hold) r_lap <= w_count;
    end
  end

  assign digits = r_hold ? r_lap : w_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign digits       = w_count;
`endif

  assign running  = r_running;
  assign overflow = r_overflow;

endmodule
